// File: rtl/rr_arb8.sv
// rr_arb8: 8-way round-robin arbiter with IDLE/GRANT/RELEASE ownership FSM.
// Optional grant timeout is built only when RR_ARB8_TIMEOUT_EN is defined.
module rr_arb8 #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] gnt_id_q, gnt_id_d;
    logic [7:0] gnt_q, gnt_d;
    logic       gnt_vld_q, gnt_vld_d;
    logic       timeout_q, timeout_d;
    logic [2:0] pick_id;
    logic       pick_vld;
    logic       tmo_hit;

    // First set request strictly after ptr, wrapping; offset 8 lands back on ptr itself.
    always_comb begin
        pick_id  = ptr_q;
        pick_vld = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (!pick_vld && req[3'(ptr_q + 3'(i))]) begin
                pick_vld = 1'b1;
                pick_id  = 3'(ptr_q + 3'(i));
            end
        end
    end

`ifdef RR_ARB8_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // Count reads 0 during the first GRANT cycle because it is held clear outside GRANT.
    always_comb begin
        cnt_d = 8'd0;
        if (state_q == GRANT) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmo_hit = (cnt_q == TMO_LAST);
`else
    logic unused_tmo_last;
    assign unused_tmo_last = ^TMO_LAST;
    assign tmo_hit         = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_id_d  = gnt_id_q;
        gnt_d     = 8'd0;
        gnt_vld_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && pick_vld) begin
                    state_d   = GRANT;
                    gnt_id_d  = pick_id;
                    gnt_d     = 8'd1 << pick_id;
                    gnt_vld_d = 1'b1;
                end
            end
            GRANT: begin
                // A voluntary release beats a timeout landing in the same cycle.
                if (done || !req[gnt_id_q]) begin
                    state_d = RELEASE;
                end else if (tmo_hit) begin
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                end else begin
                    gnt_d     = gnt_q;
                    gnt_vld_d = 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
                ptr_d   = gnt_id_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd7;
            gnt_id_q  <= 3'd0;
            gnt_q     <= 8'd0;
            gnt_vld_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_id_q  <= gnt_id_d;
            gnt_q     <= gnt_d;
            gnt_vld_q <= gnt_vld_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gnt_vld = gnt_vld_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Bench for rr_arb8: ownership-level model checked every cycle plus directed literal checks.
module tb_rr_arb8;

    localparam int TCYC = 4;
`ifdef RR_ARB8_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] req = 8'd0;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;
    logic       timeout;

    int total = 0;
    int bad = 0;

    rr_arb8 #(.TIMEOUT_CYC(TCYC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Model: who owns the resource, who owned it last, and whether we are in the post-release gap.
    int m_owner = -1;
    int m_last = 7;
    int m_held = 0;
    int m_gap = 0;
    bit m_to = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1; m_last = 7; m_held = 0; m_gap = 0; m_to = 1'b0;
            end else begin
                m_to = 1'b0;
                if (m_owner >= 0) begin
                    m_held++;
                    if (done || !req[m_owner]) begin
                        m_last = m_owner; m_owner = -1; m_gap = 1;
                    end else if (TMO_ON && m_held >= TCYC) begin
                        m_last = m_owner; m_owner = -1; m_gap = 1; m_to = 1'b1;
                    end
                end else if (m_gap > 0) begin
                    m_gap--;
                end else if (en && req != 8'd0) begin
                    for (int k = 1; k <= 8; k++) begin
                        if (req[(m_last + k) % 8]) begin
                            m_owner = (m_last + k) % 8;
                            m_held = 0;
                            break;
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("cmp_vld", 32'(gnt_vld), 32'(m_owner >= 0));
            check("cmp_tmo", 32'(timeout), 32'(m_to));
            if (m_owner >= 0) begin
                check("cmp_gnt", 32'(gnt), 32'(8'd1 << m_owner));
                check("cmp_id", 32'(gnt_id), 32'(m_owner));
            end else begin
                check("cmp_gnt", 32'(gnt), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; done = 1'b0; en = 1'b0; req = 8'd0;
        step();
        rst_n = 1'b1;
    endtask

    // Optionally pulse done for one edge, then step until a grant shows; n = edges taken.
    task automatic next_grant(input logic use_done, output int n);
        done = use_done;
        n = 0;
        do begin
            step();
            done = 1'b0;
            n++;
        end while (!gnt_vld && n < 12);
        if (!gnt_vld) begin
            total++; bad++;
            $display("FAIL grant_wait: got no grant after %0d cycles want grant", n);
        end
    endtask

    initial begin
        int n;
        int hi;
        #1;
        check("rst_gnt", 32'(gnt), 32'h00);
        check("rst_vld", 32'(gnt_vld), 32'd0);
        check("rst_id", 32'(gnt_id), 32'd0);
        check("rst_tmo", 32'(timeout), 32'd0);
        #11;
        rst_n = 1'b1; en = 1'b1; req = 8'h81;

        // 0x81: 0 first, then 7, then 0 again
        next_grant(1'b0, n);
        check("t81_lat", 32'(n), 32'd1);
        check("t81_g0", 32'(gnt), 32'h01);
        next_grant(1'b1, n);
        check("t81_gap", 32'(n), 32'd3);
        check("t81_g7", 32'(gnt), 32'h80);
        check("t81_id7", 32'(gnt_id), 32'd7);
        next_grant(1'b1, n);
        check("t81_g0b", 32'(gnt), 32'h01);

        // all requesting: ids 0..7,0 with a two-cycle gap
        do_reset();
        en = 1'b1; req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            next_grant(k > 0, n);
            check("rr_id", 32'(gnt_id), 32'(k % 8));
            check("rr_edges", 32'(n), (k == 0) ? 32'd1 : 32'd3);
        end

        // owner 3 survives en=0; no new grant until en returns
        do_reset();
        en = 1'b1; req = 8'h08;
        next_grant(1'b0, n);
        check("en_id3", 32'(gnt_id), 32'd3);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("en_hold", 32'(gnt), 32'h08);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("en_blk", 32'(gnt_vld), 32'd0);
            step();
        end
        en = 1'b1;
        step();
        check("en_regnt", 32'(gnt), 32'h08);

        // owner 5 drops req: release, then search from 6
        do_reset();
        en = 1'b1; req = 8'h20;
        next_grant(1'b0, n);
        check("drop_id5", 32'(gnt_id), 32'd5);
        req = 8'h41;
        step();
        check("drop_rel", 32'(gnt_vld), 32'd0);
        step();
        check("drop_idle", 32'(gnt_vld), 32'd0);
        step();
        check("drop_vld", 32'(gnt_vld), 32'd1);
        check("drop_id6", 32'(gnt_id), 32'd6);

        // asynchronous reset between edges mid-grant
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_gnt", 32'(gnt), 32'h00);
        check("arst_vld", 32'(gnt_vld), 32'd0);
        req = 8'h10;
        #2;
        rst_n = 1'b1;
        step();
        check("arst_g10", 32'(gnt), 32'h10);

        // lone requester is re-granted after release
        next_grant(1'b1, n);
        check("solo_id4", 32'(gnt_id), 32'd4);
        check("solo_gap", 32'(n), 32'd3);

`ifdef RR_ARB8_TIMEOUT_EN
        do_reset();
        en = 1'b1; req = 8'h0C;
        next_grant(1'b0, n);
        check("tmo_id2", 32'(gnt_id), 32'd2);
        hi = 1;
        for (int k = 0; k < 20 && gnt_vld; k++) begin
            check("tmo_early", 32'(timeout), 32'd0);
            step();
            if (gnt_vld) hi++;
        end
        check("tmo_len", 32'(hi), 32'd4);
        check("tmo_pulse", 32'(timeout), 32'd1);
        step();
        check("tmo_once", 32'(timeout), 32'd0);
        step();
        check("tmo_next3", 32'(gnt_id), 32'd3);
`endif

        done = 1'b1;
        step();
        done = 1'b0; req = 8'd0;
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
